// File: rtl/instr_fetch_unit.sv
// PC sequencer + QDEPTH-entry fetch queue; first instruction valid 2 cycles after fetch_en, then 1/cycle; fetch stalls (pc holds) while the queue is full and unpopped.
// Optional bounds/alignment halt is enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'd0,
  parameter int          QDEPTH    = 2,
  parameter int          MEM_BYTES = 160
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [63:0] mem_addr,
  input  logic [31:0] mem_instr,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        fault
);

  localparam int PW = (QDEPTH > 2) ? 2 : 1;
  localparam int CW = $clog2(QDEPTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t        q [QDEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [63:0]   pc;

  logic full;
  logic redir;
  logic pop;
  logic push_req;
  logic push;
  logic halt_go;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A halted unit ignores redirects; only reset brings it back.
  assign redir    = redirect && (state != ST_HALT);
  assign full     = (count == CW'(QDEPTH));
  assign pop      = out_valid && out_ready && !redir;
  assign push_req = (state == ST_FETCH) && fetch_en && !redirect && (!full || pop);

`ifdef FETCH_BOUNDS_CHECK_EN
  logic pc_bad;
  logic redir_bad;
  logic fault_q;

  assign pc_bad    = (pc > 64'(MEM_BYTES - 4)) || (pc[1:0] != 2'b00);
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
  assign push      = push_req && !pc_bad;
  assign halt_go   = (push_req && pc_bad) || (redir && redir_bad);

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else if (halt_go) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  assign push    = push_req;
  assign halt_go = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    count_nxt = count;
    if (redir || halt_go) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // FULL means "full and stalled": a full queue popped while in FETCH keeps streaming.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (fetch_en) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!fetch_en)         state_nxt = ST_IDLE;
        else if (full && !pop) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        if (pop) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_HALT;
    endcase
    if (redir)   state_nxt = fetch_en ? ST_FETCH : ST_IDLE;
    if (halt_go) state_nxt = ST_HALT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (redir) begin
        pc   <= redirect_pc;
        head <= '0;
        tail <= '0;
      end else if (halt_go) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          tail <= ptr_inc(tail);
          pc   <= pc + 64'd4;
        end
        if (pop) begin
          head <= ptr_inc(head);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q[tail] <= '{instr: mem_instr, pc: pc};
    end
  end

  assign mem_addr  = pc;
  assign out_valid = (count != '0);
  assign out_instr = out_valid ? q[head].instr : 32'd0;
  assign out_pc    = out_valid ? q[head].pc    : 64'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit against a 160-byte little-endian ROM model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic [63:0] mem_addr;
  logic [31:0] mem_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rom_w [40];

  instr_fetch_unit #(.RESET_PC(64'd0), .QDEPTH(2), .MEM_BYTES(160)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_en   (fetch_en),
    .mem_addr   (mem_addr),
    .mem_instr  (mem_instr),
    .out_valid  (out_valid),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_ready  (out_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [63:0] a);
    logic [31:0] w;
    if (a >= 64'd160) return 8'h00;
    w = rom_w[a[7:2]];
    return w[8*a[1:0] +: 8];
  endfunction

  assign mem_instr = {rd_byte(mem_addr + 64'd3), rd_byte(mem_addr + 64'd2),
                      rd_byte(mem_addr + 64'd1), rd_byte(mem_addr)};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    fetch_en = 1'b0;
    redirect = 1'b0;
    tick(1);
    reset    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 40; i++) rom_w[i] = 32'h1000_0000 + 32'(i * 4);
    rom_w[0]  = 32'h0040_0593;
    rom_w[1]  = 32'h0000_0313;
    rom_w[16] = 32'h0003_0393;
    rom_w[39] = 32'hFA00_04E3;

    reset       = 1'b1;
    fetch_en    = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 64'd0;
    tick(2);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc",    out_pc,         64'd0);
    chk("rst_addr",  mem_addr,       64'd0);
    chk("rst_fault", 64'(fault),     64'd0);

    // Streaming fetch from reset.
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    tick(1);
    chk("lat_c1_valid", 64'(out_valid), 64'd0);
    tick(1);
    chk("lat_c2_valid", 64'(out_valid), 64'd1);
    chk("lat_c2_pc",    out_pc,         64'd0);
    chk("lat_c2_instr", 64'(out_instr), 64'h0040_0593);
    tick(1);
    chk("strm_pc4",     out_pc,         64'd4);
    chk("strm_instr4",  64'(out_instr), 64'h0000_0313);
    tick(1);
    chk("strm_pc8",     out_pc,         64'd8);
    chk("strm_instr8",  64'(out_instr), 64'h1000_0008);
    chk("strm_addr",    mem_addr,       64'd12);

    // Stall with out_ready low, then drain in order.
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(5);
    chk("stall_addr",  mem_addr,       64'd8);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_pc",    out_pc,         64'd0);
    out_ready = 1'b1;
    tick(1);
    chk("drain_pc4",   out_pc,   64'd4);
    chk("drain_addr",  mem_addr, 64'd8);
    tick(1);
    chk("drain_pc8",   out_pc,         64'd8);
    chk("drain_ins8",  64'(out_instr), 64'h1000_0008);
    tick(1);
    chk("drain_pc12",  out_pc,   64'd12);

    // Full queue popped and pushed in the same cycle.
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(3);
    chk("full_pc0",   out_pc,   64'd0);
    chk("full_addr8", mem_addr, 64'd8);
    out_ready = 1'b1;
    tick(1);
    chk("pp_pc4",     out_pc,         64'd4);
    chk("pp_addr12",  mem_addr,       64'd12);
    chk("pp_valid",   64'(out_valid), 64'd1);
    out_ready = 1'b0;
    tick(2);
    chk("pp_hold_addr", mem_addr, 64'd12);
    chk("pp_hold_pc",   out_pc,   64'd4);
    out_ready = 1'b1;
    tick(1);
    chk("pp_order8",  out_pc, 64'd8);
    tick(1);
    chk("pp_order12", out_pc, 64'd12);

    // Redirect with two queued entries and a simultaneous pop.
    out_ready = 1'b0;
    tick(1);
    redirect = 1'b1; redirect_pc = 64'h40; out_ready = 1'b1;
    tick(1);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr",  mem_addr,       64'h40);
    redirect = 1'b0;
    tick(1);
    chk("redir_pc",    out_pc,         64'h40);
    chk("redir_instr", 64'(out_instr), 64'h0003_0393);
    tick(1);
    chk("redir_next",  out_pc,         64'h44);

    // End-of-memory behaviour.
    redirect = 1'b1; redirect_pc = 64'h9C;
    tick(1);
    redirect = 1'b0;
    tick(1);
    chk("bnd_pc9c",    out_pc,         64'h9C);
    chk("bnd_ins9c",   64'(out_instr), 64'hFA00_04E3);
    chk("bnd_fault0",  64'(fault),     64'd0);
    tick(1);
`ifdef FETCH_BOUNDS_CHECK_EN
    chk("bnd_fault1",  64'(fault),     64'd1);
    chk("bnd_flush",   64'(out_valid), 64'd0);
    redirect = 1'b1; redirect_pc = 64'h40;
    tick(1);
    redirect = 1'b0;
    tick(1);
    chk("halt_sticky", 64'(fault),     64'd1);
    chk("halt_novld",  64'(out_valid), 64'd0);
    chk("halt_addr",   mem_addr,       64'hA0);
    do_reset();
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 64'h06;
    tick(1);
    redirect = 1'b0;
    chk("mis_fault",   64'(fault),     64'd1);
    chk("mis_valid",   64'(out_valid), 64'd0);
`else
    chk("nochk_fault", 64'(fault),     64'd0);
    chk("nochk_pca0",  out_pc,         64'hA0);
    chk("nochk_insa0", 64'(out_instr), 64'd0);
    do_reset();
    fetch_en = 1'b1; redirect = 1'b1; redirect_pc = 64'h06;
    tick(1);
    redirect = 1'b0;
    chk("mis_addr",    mem_addr,       64'h06);
    tick(1);
    chk("mis_pc",      out_pc,         64'h06);
    chk("mis_instr",   64'(out_instr), 64'h0008_0000);
    chk("mis_fault",   64'(fault),     64'd0);
`endif

    // Reset mid-operation with a pending redirect.
    do_reset();
    fetch_en = 1'b1; out_ready = 1'b0;
    tick(3);
    chk("mid_valid_pre", 64'(out_valid), 64'd1);
    reset = 1'b1; redirect = 1'b1; redirect_pc = 64'h80;
    tick(1);
    reset = 1'b0; redirect = 1'b0; fetch_en = 1'b0;
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_addr",  mem_addr,       64'd0);
    chk("mid_fault", 64'(fault),     64'd0);
    tick(2);
    chk("mid_idle_valid", 64'(out_valid), 64'd0);
    chk("mid_idle_addr",  mem_addr,       64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
